// File: rtl/fifo_uart_drain_if.sv
// Read-side handshake between the synchronous FIFO and its single UART drain.
// master = the drain (issues pops), slave = the FIFO (supplies flag and data).
interface fifo_uart_drain_if #(
  parameter int WIDTH = 8
);
  logic             fifo_rd_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout
  );
endinterface

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the FIFO and serialises each as start / LSB-first data / stop on tx.
// Define PARITY_EN to insert an even-parity bit between the data and the stop bit(s).
module fifo_uart_drain #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  fifo_uart_drain_if.master fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
`ifdef PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic baud_wrap;
  logic can_fetch;

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign can_fetch = enable && !fifo.fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      tx_q         <= tx_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // enable/fifo_empty are only consulted in IDLE and on the last cycle of STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (can_fetch) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = fifo.fifo_dout;
`ifdef PARITY_EN
        parity_d = ^fifo.fifo_dout;
`endif
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = can_fetch ? FETCH : IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values so their flops line up with state_q.
  always_comb begin
    rd_en_d      = (state_d == FETCH);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    tx_d         = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Scoreboard bench: a FIFO model feeds the drain, a monitor decodes tx frames and
// compares each against the bytes pushed, in push order (PARITY_EN honoured).
module tb_fifo_uart_drain;

  localparam int WIDTH     = 8;
  localparam int CPB       = 4;
  localparam int STOP_BITS = 1;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + WIDTH + P + STOP_BITS;
  localparam int FL    = NBITS * CPB;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic tx, busy, frame_done;

  fifo_uart_drain_if #(.WIDTH(WIDTH)) fifo_bus ();

  fifo_uart_drain #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo(fifo_bus),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO model: registered read data, one cycle after rd_en is sampled.
  logic [WIDTH-1:0] fifo_mem[$];
  logic             push_valid = 1'b0;
  logic [WIDTH-1:0] push_data  = '0;
  int               pop_cnt    = 0;

  initial begin
    fifo_bus.fifo_empty = 1'b1;
    fifo_bus.fifo_dout  = '0;
    forever begin
      @(posedge clk);
      if (fifo_bus.fifo_rd_en) begin
        check_output("no_underflow", int'(fifo_mem.size() == 0), 0);
        if (fifo_mem.size() != 0) begin
          fifo_bus.fifo_dout <= fifo_mem.pop_front();
          pop_cnt++;
        end
      end
      if (push_valid) fifo_mem.push_back(push_data);
      fifo_bus.fifo_empty <= (fifo_mem.size() == 0);
    end
  end

  logic [WIDTH-1:0] exp_mem[512];
  int exp_wr = 0;
  int exp_rd = 0;
  int discard_cnt = 0;
  int discard_seen = 0;
  int frame_cnt = 0;
  int gap_cnt = 0;
  int stray_fd = 0;
  int mon_pos = -1;
  int gap_log[256];
  logic [NBITS-1:0] frame_bits;
  logic glitch, fd_ok, busy_ok;

  task automatic finish_frame();
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] want;
    got = frame_bits[WIDTH:1];
    if (exp_rd >= exp_wr) begin
      check_output("frame_pending", exp_wr - exp_rd, 1);
    end else begin
      want = exp_mem[exp_rd];
      exp_rd++;
      check_output("frame_data", int'(got), int'(want));
`ifdef PARITY_EN
      check_output("parity_bit", int'(frame_bits[WIDTH+1]), int'(^want));
`endif
    end
    check_output("start_bit", int'(frame_bits[0]), 0);
    check_output("stop_bits", int'(frame_bits[NBITS-1 -: STOP_BITS]), (1 << STOP_BITS) - 1);
    check_output("bit_stable", int'(glitch), 0);
    check_output("frame_done_pos", int'(fd_ok), 1);
    check_output("busy_in_frame", int'(busy_ok), 1);
    frame_cnt++;
  endtask

  // Monitor: decodes frames from tx, sampled on the falling edge.
  initial begin
    int bidx;
    forever begin
      @(negedge clk);
      while (discard_seen < discard_cnt) begin
        exp_rd++;
        discard_seen++;
      end
      if (!rst) begin
        mon_pos = -1;
        gap_cnt = 0;
      end else begin
        if (mon_pos < 0 && tx == 1'b0) begin
          mon_pos = 0;
          if (frame_cnt < 256) gap_log[frame_cnt] = gap_cnt;
          glitch = 1'b0;
          fd_ok = 1'b1;
          busy_ok = 1'b1;
          frame_bits = '0;
        end
        if (mon_pos >= 0) begin
          bidx = mon_pos / CPB;
          if (mon_pos % CPB == 0) frame_bits[bidx] = tx;
          else if (tx != frame_bits[bidx]) glitch = 1'b1;
          if (frame_done != (mon_pos == FL - 1)) fd_ok = 1'b0;
          if (!busy) busy_ok = 1'b0;
          if (mon_pos == FL - 1) begin
            finish_frame();
            mon_pos = -1;
            gap_cnt = 0;
          end else begin
            mon_pos++;
          end
        end else begin
          gap_cnt++;
          if (frame_done) stray_fd++;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [WIDTH-1:0] b);
    @(negedge clk);
    push_valid = 1'b1;
    push_data = b;
    exp_mem[exp_wr] = b;
    exp_wr++;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_pop(input int p0, input int budget);
    for (int i = 0; i < budget && pop_cnt == p0; i++) @(negedge clk);
    check_output("pop_seen", int'(pop_cnt > p0), 1);
  endtask

  task automatic wait_fd(input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    check_output("frame_done_seen", seen, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_rd == exp_wr && mon_pos < 0 && fifo_mem.size() == 0 && !busy) break;
    end
    check_output("drained", exp_wr - exp_rd, 0);
  endtask

  initial begin
    int p0, f0, n, lows, seen;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_tx", int'(tx), 1);
    check_output("reset_rd_en", int'(fifo_bus.fifo_rd_en), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_frame_done", int'(frame_done), 0);
    rst = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check_output("idle_empty_tx", int'(tx), 1);
    check_output("idle_empty_busy", int'(busy), 0);
    check_output("idle_empty_pops", pop_cnt, 0);

    // Single frame: length from START entry to frame_done, then busy release.
    p0 = pop_cnt;
    apply_stimulus(8'h06);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (!tx) seen = 1;
    end
    check_output("start_seen", seen, 1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) break;
    end
    check_output("frame_len", n, FL);
    @(negedge clk);
    check_output("busy_after_done", int'(busy), 0);
    check_output("single_pops", pop_cnt - p0, 1);

    // Back-to-back frames: FETCH+LOAD gap only.
    enable = 1'b0;
    apply_stimulus(8'h34);
    apply_stimulus(8'h24);
    f0 = frame_cnt;
    p0 = pop_cnt;
    enable = 1'b1;
    for (int i = 0; i < 500 && frame_cnt < f0 + 2; i++) @(negedge clk);
    check_output("b2b_frames", frame_cnt - f0, 2);
    check_output("b2b_gap", gap_log[f0+1], 2);
    check_output("b2b_pops", pop_cnt - p0, 2);

    // Disabled with data waiting, then enable dropped mid-frame.
    enable = 1'b0;
    apply_stimulus(8'h31);
    apply_stimulus(8'h5A);
    p0 = pop_cnt;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check_output("disabled_tx_low", lows, 0);
    check_output("disabled_pops", pop_cnt - p0, 0);
    enable = 1'b1;
    wait_pop(p0, 100);
    repeat (15) @(negedge clk);
    enable = 1'b0;
    wait_fd(200);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check_output("after_disable_tx_low", lows, 0);
    check_output("after_disable_pops", pop_cnt - p0, 1);
    enable = 1'b1;
    wait_drain(500);

    // Reset mid-DATA discards the in-flight word.
    enable = 1'b0;
    apply_stimulus(8'h22);
    apply_stimulus(8'h35);
    p0 = pop_cnt;
    enable = 1'b1;
    wait_pop(p0, 100);
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    discard_cnt++;
    #1;
    check_output("mid_reset_tx", int'(tx), 1);
    check_output("mid_reset_rd_en", int'(fifo_bus.fifo_rd_en), 0);
    check_output("mid_reset_busy", int'(busy), 0);
    check_output("mid_reset_frame_done", int'(frame_done), 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    f0 = frame_cnt;
    wait_drain(500);
    check_output("frames_after_reset", frame_cnt - f0, 1);

`ifdef PARITY_EN
    apply_stimulus(8'h34);
    apply_stimulus(8'h06);
    wait_drain(500);
`endif

    for (int it = 0; it < 40; it++) begin
      enable = ($urandom_range(0, 7) != 0);
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) apply_stimulus(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    enable = 1'b1;
    wait_drain(20000);

    check_output("stray_frame_done", stray_fd, 0);
    check_output("fifo_left", fifo_mem.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
